// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: boot stream, fetch, load/store and status signals
// between the single-cycle core side (master) and the memory responder (slave).
interface cpu_mem_responder_if;
  logic        boot_valid;
  logic        boot_ready;
  logic [31:0] boot_data;
  logic        boot_last;
  logic        cpu_rst_n;
  logic [31:0] PC;
  logic        en_fetch;
  logic [31:0] instruction;
  logic        en_fetch_data;
  logic        en_store_data;
  logic [31:0] alu_result;
  logic [31:0] Rdata2;
  logic [31:0] data_m;
  logic        halted;
  logic [31:0] exit_code;
  logic        boot_err;

  modport slave (
    input  boot_valid, boot_data, boot_last,
    input  PC, en_fetch, en_fetch_data, en_store_data, alu_result, Rdata2,
    output boot_ready, cpu_rst_n, instruction, data_m, halted, exit_code, boot_err
  );

  modport master (
    output boot_valid, boot_data, boot_last,
    output PC, en_fetch, en_fetch_data, en_store_data, alu_result, Rdata2,
    input  boot_ready, cpu_rst_n, instruction, data_m, halted, exit_code, boot_err
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory-side responder for the single-cycle core.
// Boot-loads instruction RAM over a valid/ready stream while holding the core
// in reset, then serves fetches, loads and stores (data RAM + MMIO window),
// and halts the core when software writes the exit register.
// Optional feature: define MISALIGN_TRAP_EN to halt on misaligned load/store
// in RUN (exit_code = 32'hDEAD_0000 | addr[15:0]).
module cpu_mem_responder #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  cpu_mem_responder_if.slave bus
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e         state_q, state_d;
  logic [IAW-1:0] ptr_q, ptr_d;
  logic           cpu_rst_n_q, cpu_rst_n_d;
  logic           halted_q, halted_d;
  logic [31:0]    exit_q, exit_d;
  logic           boot_err_q, boot_err_d;
  logic [31:0]    cyc_q, cyc_d;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic           imem_we;
  logic           dmem_we;
  logic [DAW-1:0] d_idx;
  logic [IAW-1:0] i_idx;
  logic [31:0]    word_addr;
  logic           in_imem;
  logic           in_dmem;
  logic           is_cyc;
  logic           is_stat;
  logic           is_exit;
  logic           misalign;

  assign word_addr = {bus.alu_result[31:2], 2'b00};
  assign in_dmem   = bus.alu_result < 32'(DMEM_WORDS * 4);
  assign in_imem   = bus.PC < 32'(IMEM_WORDS * 4);
  assign is_cyc    = word_addr == MMIO_BASE;
  assign is_stat   = word_addr == (MMIO_BASE + 32'h4);
  assign is_exit   = word_addr == (MMIO_BASE + 32'h8);
  assign d_idx     = bus.alu_result[DAW+1:2];
  assign i_idx     = bus.PC[IAW+1:2];

`ifdef MISALIGN_TRAP_EN
  assign misalign = (state_q == ST_RUN) && (bus.alu_result[1:0] != 2'b00) &&
                    (bus.en_fetch_data || bus.en_store_data);
`else
  assign misalign = 1'b0;
`endif

  // Control state register, cleared asynchronously; RAMs are not reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_BOOT;
      ptr_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      halted_q    <= 1'b0;
      exit_q      <= '0;
      boot_err_q  <= 1'b0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      halted_q    <= halted_d;
      exit_q      <= exit_d;
      boot_err_q  <= boot_err_d;
      cyc_q       <= cyc_d;
    end
  end

  // Next-state logic: boot loading, RUN bookkeeping, store decode and halting.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cpu_rst_n_d = cpu_rst_n_q;
    halted_d    = halted_q;
    exit_d      = exit_q;
    boot_err_d  = boot_err_q;
    cyc_d       = cyc_q;
    imem_we     = 1'b0;
    dmem_we     = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        cpu_rst_n_d = 1'b0;
        if (bus.boot_valid) begin
          imem_we = 1'b1;
          ptr_d   = ptr_q + IAW'(1);
          if (bus.boot_last) begin
            state_d = ST_RUN;
          end else if (ptr_q == '1) begin
            state_d    = ST_RUN;
            boot_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cyc_d       = cyc_q + 32'd1;
        cpu_rst_n_d = 1'b1;
        if (misalign) begin
          exit_d      = 32'hDEAD_0000 | {16'h0000, bus.alu_result[15:0]};
          halted_d    = 1'b1;
          state_d     = ST_HALT;
          cpu_rst_n_d = 1'b0;
        end else if (bus.en_store_data) begin
          if (in_dmem) begin
            dmem_we = 1'b1;
          end else if (is_exit) begin
            exit_d      = bus.Rdata2;
            halted_d    = 1'b1;
            state_d     = ST_HALT;
            cpu_rst_n_d = 1'b0;
          end
        end
      end
      ST_HALT: begin
        cpu_rst_n_d = 1'b0;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // RAM write ports; the combinational read below sees the old word (read-before-write).
  always_ff @(posedge clk_i) begin
    if (imem_we) imem[ptr_q] <= bus.boot_data;
    if (dmem_we) dmem[d_idx] <= bus.Rdata2;
  end

  // Zero-latency fetch and load decode.
  always_comb begin
    bus.instruction = NOP;
    if (bus.en_fetch && in_imem && (state_q != ST_HALT)) begin
      bus.instruction = imem[i_idx];
    end
    bus.data_m = '0;
    if (bus.en_fetch_data && !misalign) begin
      if (in_dmem)      bus.data_m = dmem[d_idx];
      else if (is_cyc)  bus.data_m = cyc_q;
      else if (is_stat) bus.data_m = {30'b0, boot_err_q, halted_q};
    end
  end

  assign bus.boot_ready = (state_q == ST_BOOT);
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.halted     = halted_q;
  assign bus.exit_code  = exit_q;
  assign bus.boot_err   = boot_err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed stimulus for cpu_mem_responder with a
// behavioural reference model compared every cycle, plus literal expectations.
module tb_cpu_mem_responder;

  localparam int unsigned IMEM_WORDS = 256;
  localparam int unsigned DMEM_WORDS = 256;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FF00;
  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_mem_responder_if bus ();

  cpu_mem_responder #(
    .IMEM_WORDS(IMEM_WORDS),
    .DMEM_WORDS(DMEM_WORDS),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = loading, 1 = running, 2 = halted
  logic [31:0] m_imem [IMEM_WORDS];
  bit          m_iv   [IMEM_WORDS];
  logic [31:0] m_dmem [DMEM_WORDS];
  bit          m_dv   [DMEM_WORDS];
  int unsigned m_mode;
  int unsigned m_ptr;
  logic [31:0] m_count, m_exit, m_a;
  bit          m_halted, m_berr, m_cpurst;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_ptr = 0; m_count = '0; m_exit = '0;
      m_halted = 0; m_berr = 0; m_cpurst = 0;
    end else if (m_mode == 0) begin
      if (bus.boot_valid) begin
        m_imem[m_ptr] = bus.boot_data;
        m_iv[m_ptr]   = 1'b1;
        if (bus.boot_last) m_mode = 1;
        else if (m_ptr == IMEM_WORDS - 1) begin m_mode = 1; m_berr = 1; end
        m_ptr = (m_ptr + 1) % IMEM_WORDS;
      end
    end else if (m_mode == 1) begin
      m_a = bus.alu_result;
      m_count = m_count + 32'd1;
      m_cpurst = 1;
      if (TRAP && (bus.en_fetch_data || bus.en_store_data) && m_a[1:0] != 2'b00) begin
        m_exit = 32'hDEAD_0000 | (m_a & 32'h0000_FFFF);
        m_halted = 1; m_mode = 2; m_cpurst = 0;
      end else if (bus.en_store_data) begin
        if (m_a < DMEM_WORDS * 4) begin
          m_dmem[m_a[DAW+1:2]] = bus.Rdata2;
          m_dv[m_a[DAW+1:2]]   = 1'b1;
        end else if ((m_a & ~32'h3) == MMIO_BASE + 32'h8) begin
          m_exit = bus.Rdata2; m_halted = 1; m_mode = 2; m_cpurst = 0;
        end
      end
    end
  end

  function automatic void exp_data(output logic [31:0] v, output bit known);
    logic [31:0] a;
    a = bus.alu_result & ~32'h3;
    v = '0;
    known = 1'b1;
    if (!bus.en_fetch_data) return;
    if (TRAP && m_mode == 1 && bus.alu_result[1:0] != 2'b00) return;
    if (a < DMEM_WORDS * 4) begin
      known = m_dv[a[DAW+1:2]];
      v = m_dmem[a[DAW+1:2]];
    end else if (a == MMIO_BASE) v = m_count;
    else if (a == MMIO_BASE + 32'h4) v = {30'b0, m_berr, m_halted};
  endfunction

  function automatic void exp_instr(output logic [31:0] v, output bit known);
    logic [31:0] p;
    p = bus.PC;
    v = 32'h0000_0013;
    known = 1'b1;
    if (m_mode == 2 || !bus.en_fetch || p >= IMEM_WORDS * 4) return;
    known = m_iv[p[IAW+1:2]];
    v = m_imem[p[IAW+1:2]];
  endfunction

  // Compare DUT outputs to the model away from the active edge.
  logic [31:0] e_v;
  bit          e_k;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_boot_ready", {31'b0, bus.boot_ready}, {31'b0, m_mode == 0});
      chk("m_cpu_rst_n",  {31'b0, bus.cpu_rst_n},  {31'b0, m_cpurst});
      chk("m_halted",     {31'b0, bus.halted},     {31'b0, m_halted});
      chk("m_boot_err",   {31'b0, bus.boot_err},   {31'b0, m_berr});
      chk("m_exit_code",  bus.exit_code, m_exit);
      exp_instr(e_v, e_k);
      if (e_k) chk("m_instruction", bus.instruction, e_v);
      exp_data(e_v, e_k);
      if (e_k) chk("m_data_m", bus.data_m, e_v);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic boot_word(input logic [31:0] d, input bit last);
    bus.boot_valid = 1'b1;
    bus.boot_data  = d;
    bus.boot_last  = last;
    step();
    bus.boot_valid = 1'b0;
    bus.boot_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] cnt_at_halt;

  initial begin
    rst_n = 1'b0;
    bus.boot_valid = 0; bus.boot_data = '0; bus.boot_last = 0;
    bus.PC = '0; bus.en_fetch = 0; bus.en_fetch_data = 0; bus.en_store_data = 0;
    bus.alu_result = '0; bus.Rdata2 = '0;
    step(); step();
    cmp_en = 1'b1;
    chk("rst_boot_ready", {31'b0, bus.boot_ready}, 32'd1);
    chk("rst_cpu_rst_n",  {31'b0, bus.cpu_rst_n},  32'd0);
    chk("rst_halted",     {31'b0, bus.halted},     32'd0);
    chk("rst_exit_code",  bus.exit_code, 32'd0);
    chk("rst_boot_err",   {31'b0, bus.boot_err},   32'd0);
    rst_n = 1'b1;

    // Boot three words with a gap cycle before the last one
    boot_word(32'h0000_0513, 0);
    boot_word(32'h0070_0593, 0);
    step();
    boot_word(32'h00B5_0633, 1);
    chk("boot_ready_drop", {31'b0, bus.boot_ready}, 32'd0);
    chk("cpu_rst_still0",  {31'b0, bus.cpu_rst_n},  32'd0);
    step();
    chk("cpu_rst_release", {31'b0, bus.cpu_rst_n},  32'd1);
    bus.en_fetch = 1; bus.PC = 32'h0; #1;
    chk("fetch0", bus.instruction, 32'h0000_0513);
    bus.PC = 32'h4; #1;
    chk("fetch1", bus.instruction, 32'h0070_0593);
    bus.PC = 32'hA; #1;
    chk("fetch2_lowbits", bus.instruction, 32'h00B5_0633);
    bus.PC = IMEM_WORDS * 4; #1;
    chk("fetch_oob_nop", bus.instruction, 32'h0000_0013);
    bus.en_fetch = 0; bus.PC = 32'h0; #1;
    chk("fetch_dis_nop", bus.instruction, 32'h0000_0013);
    bus.en_fetch_data = 1; bus.alu_result = MMIO_BASE; #1;
    chk("cycle_cnt_1", bus.data_m, 32'd1);
    repeat (4) step();
    chk("cycle_cnt_5", bus.data_m, 32'd5);

    // Store then load; read-before-write on a simultaneous load/store
    bus.en_fetch_data = 0; bus.en_store_data = 1;
    bus.alu_result = 32'h10; bus.Rdata2 = 32'hCAFE_F00D;
    step();
    bus.en_store_data = 0; bus.en_fetch_data = 1; #1;
    chk("load_cafe", bus.data_m, 32'hCAFE_F00D);
    bus.en_store_data = 1; bus.Rdata2 = 32'h1; #1;
    chk("rbw_old", bus.data_m, 32'hCAFE_F00D);
    step();
    bus.en_store_data = 0; #1;
    chk("rbw_new", bus.data_m, 32'h1);
    bus.alu_result = DMEM_WORDS * 4; #1;
    chk("load_unmapped", bus.data_m, 32'h0);
    bus.alu_result = MMIO_BASE + 32'h4; #1;
    chk("status_run", bus.data_m, 32'h0);
    bus.alu_result = MMIO_BASE + 32'hC; #1;
    chk("mmio_other", bus.data_m, 32'h0);

    // Exit write halts on the same edge
    bus.en_fetch_data = 0; bus.en_store_data = 1;
    bus.alu_result = MMIO_BASE + 32'h8; bus.Rdata2 = 32'd7;
    step();
    bus.en_store_data = 0;
    chk("halt_halted",  {31'b0, bus.halted},    32'd1);
    chk("halt_exit",    bus.exit_code,          32'd7);
    chk("halt_cpu_rst", {31'b0, bus.cpu_rst_n}, 32'd0);
    bus.en_fetch = 1; bus.PC = 32'h0; #1;
    chk("halt_fetch_nop", bus.instruction, 32'h0000_0013);
    cnt_at_halt = m_count;
    bus.en_fetch_data = 1; bus.alu_result = MMIO_BASE;
    repeat (3) step();
    chk("cnt_frozen", bus.data_m, cnt_at_halt);
    bus.en_fetch_data = 0; bus.en_store_data = 1;
    bus.alu_result = 32'h10; bus.Rdata2 = 32'h99;
    step();
    bus.en_store_data = 0; bus.en_fetch_data = 1; #1;
    chk("halt_store_ign", bus.data_m, 32'h1);
    chk("halt_exit_hold", bus.exit_code, 32'd7);

    // Boot overflow, then asynchronous reset mid-RUN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_halted", {31'b0, bus.halted}, 32'd0);
    for (int unsigned i = 0; i < IMEM_WORDS; i++) boot_word(32'h1000_0000 + i, 0);
    chk("ovf_boot_err", {31'b0, bus.boot_err},   32'd1);
    chk("ovf_ready",    {31'b0, bus.boot_ready}, 32'd0);
    bus.alu_result = MMIO_BASE + 32'h4; #1;
    chk("ovf_status", bus.data_m, 32'd2);
    bus.PC = IMEM_WORDS * 4 - 4; #1;
    chk("ovf_last_word", bus.instruction, 32'h1000_00FF);
    bus.PC = 32'h0; #1;
    chk("ovf_first_word", bus.instruction, 32'h1000_0000);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cpu_rst", {31'b0, bus.cpu_rst_n},  32'd0);
    chk("arst_berr",    {31'b0, bus.boot_err},   32'd0);
    chk("arst_ready",   {31'b0, bus.boot_ready}, 32'd1);
    step();
    rst_n = 1'b1;

    // Misaligned store
    bus.en_fetch_data = 0;
    boot_word(32'h0000_0093, 1);
    step();
    bus.en_store_data = 1; bus.alu_result = 32'h12; bus.Rdata2 = 32'h55;
    step();
    bus.en_store_data = 0; bus.en_fetch_data = 1; bus.alu_result = 32'h10; #1;
`ifdef MISALIGN_TRAP_EN
    chk("mis_halted", {31'b0, bus.halted}, 32'd1);
    chk("mis_exit",   bus.exit_code, 32'hDEAD_0012);
    chk("mis_dmem",   bus.data_m, 32'h1);
`else
    chk("mis_halted", {31'b0, bus.halted}, 32'd0);
    chk("mis_dmem",   bus.data_m, 32'h55);
    bus.alu_result = 32'h12; #1;
    chk("mis_load",   bus.data_m, 32'h55);
`endif
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
